// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: default widths and the register-address type
// used by decode, the hazard unit and the register file.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port: zero-register / writeback-bypass / array mux
// plus the busy flag masked by a same-cycle writeback.
module reg_read_port
  import mips_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] array_data,
  input  logic              busy_bit,
  output logic [DATA_W-1:0] data,
  output logic              busy
);

  logic is_zero;
  logic wr_hit;

  always_comb begin
    is_zero = (ZERO_REG != 0) && (addr == ADDR_W'(ZERO_ADDR));
    wr_hit  = wr_en && (wr_addr == addr);
    data    = array_data;
    if (is_zero) begin
      data = '0;
    end else if (wr_hit && !rst) begin
      data = wr_data;
    end
    // A producer writing back this cycle is already satisfied by the bypass.
    busy = busy_bit && !wr_hit && !is_zero;
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with NREAD combinational read ports, one edge-triggered write
// port, write-to-read bypass, optional hardwired r0 and a busy scoreboard.
module reg_file_sb
  import mips_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREAD*ADDR_W-1:0] RD_ADDR,
  output logic [NREAD*DATA_W-1:0] RD_DATA,
  output logic [NREAD-1:0]        RD_BUSY,
  input  logic                    WR_EN,
  input  logic [ADDR_W-1:0]       WR_ADDR,
  input  logic [DATA_W-1:0]       WR_DATA,
  input  logic                    ISSUE_EN,
  input  logic [ADDR_W-1:0]       ISSUE_ADDR,
  output logic [ADDR_W:0]         BUSY_CNT
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy_reg;
  logic [DEPTH-1:0]  busy_next;
  logic [ADDR_W:0]   busy_cnt_reg;
  logic [ADDR_W:0]   busy_cnt_next;
  logic              wr_ok;
  logic              issue_ok;

  always_comb begin
    wr_ok    = WR_EN && !((ZERO_REG != 0) && (WR_ADDR == ADDR_W'(ZERO_ADDR)));
    issue_ok = ISSUE_EN && !((ZERO_REG != 0) && (ISSUE_ADDR == ADDR_W'(ZERO_ADDR)));

    // Clear first, then set: a newly issued producer supersedes the writeback.
    busy_next = busy_reg;
    if (WR_EN) begin
      busy_next[WR_ADDR] = 1'b0;
    end
    if (issue_ok) begin
      busy_next[ISSUE_ADDR] = 1'b1;
    end

    busy_cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_next = busy_cnt_next + (ADDR_W + 1)'(busy_next[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy_reg     <= '0;
      busy_cnt_reg <= '0;
    end else begin
      if (wr_ok) begin
        mem[WR_ADDR] <= WR_DATA;
      end
      busy_reg     <= busy_next;
      busy_cnt_reg <= busy_cnt_next;
    end
  end

  assign BUSY_CNT = busy_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      assign addr = RD_ADDR[gi*ADDR_W +: ADDR_W];

      reg_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
      ) u_port (
        .addr      (addr),
        .rst       (RST),
        .wr_en     (WR_EN),
        .wr_addr   (WR_ADDR),
        .wr_data   (WR_DATA),
        .array_data(mem[addr]),
        .busy_bit  (busy_reg[addr]),
        .data      (RD_DATA[gi*DATA_W +: DATA_W]),
        .busy      (RD_BUSY[gi])
      );
    end
  endgenerate

endmodule
